// File: rtl/alu_share_arb.sv
// -----------------------------------------------------------------------------
// alu_share_arb
//   Time-shares one combinational 32-bit ALU between two requesters. Each cycle
//   at most one eligible requester is granted. Its operands go through the
//   shared ALU, and the result is captured into that requester's one-entry
//   response slot. The slot is held until the requester drains it.
//
//   Configuration macro: ALU_SHARE_ARB_RR_EN
//     defined   : round-robin on conflict (the port granted least recently wins)
//     undefined : fixed priority (port 0 always wins a conflict)
//
// Ports (N = 0, 1):
//   clk            in   clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   pN_req_valid   in   operation request present
//   pN_req_ready   out  grant (request accepted this cycle)
//   pN_A, pN_B     in   operands
//   pN_ALUOp       in   opcode (0 add, 1 sub, 2 or, 3 slt, 4 lui, else 0)
//   pN_shamt       in   shift amount (carried, unused by the current op set)
//   pN_resp_valid  out  slot holds an unread result
//   pN_resp_ready  in   requester consumes the result this cycle
//   pN_C           out  result register
// -----------------------------------------------------------------------------
module alu_share_arb #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             p0_req_valid,
   output logic             p0_req_ready,
   input  logic [WIDTH-1:0] p0_A,
   input  logic [WIDTH-1:0] p0_B,
   input  logic [3:0]       p0_ALUOp,
   input  logic [4:0]       p0_shamt,
   output logic             p0_resp_valid,
   input  logic             p0_resp_ready,
   output logic [WIDTH-1:0] p0_C,
   input  logic             p1_req_valid,
   output logic             p1_req_ready,
   input  logic [WIDTH-1:0] p1_A,
   input  logic [WIDTH-1:0] p1_B,
   input  logic [3:0]       p1_ALUOp,
   input  logic [4:0]       p1_shamt,
   output logic             p1_resp_valid,
   input  logic             p1_resp_ready,
   output logic [WIDTH-1:0] p1_C
);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_OR  = 4'd2;
   localparam logic [3:0] OP_SLT = 4'd3;
   localparam logic [3:0] OP_LUI = 4'd4;

   function automatic logic [WIDTH-1:0] alu_eval(
      input logic signed [WIDTH-1:0] a,
      input logic signed [WIDTH-1:0] b,
      input logic        [3:0]       op
   );
      logic [WIDTH-1:0] r;
      r = '0;
      case (op)
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_OR:   r = a | b;
         OP_SLT:  r = (a < b) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
         OP_LUI:  r = b << 16;
         default: r = '0;
      endcase
      return r;
   endfunction

   logic             full0, full1;
   logic             elig0, elig1;
   logic             win0, win1;
   logic [WIDTH-1:0] sel_a, sel_b, alu_c;
   logic [3:0]       sel_op;
   logic [4:0]       sel_shamt;
   logic             unused_shamt;

   // ---- arbitration: eligibility, winner, grant ----
   // A full slot that is drained this cycle frees up in time for a new result.
   assign elig0 = p0_req_valid & (~full0 | p0_resp_ready);
   assign elig1 = p1_req_valid & (~full1 | p1_resp_ready);

`ifdef ALU_SHARE_ARB_RR_EN
   // last_p1 = 1 when port 1 holds the most recent grant; the reset value
   // makes port 0 win the first conflict.
   logic last_p1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)          last_p1 <= 1'b1;
      else if (p0_req_ready) last_p1 <= 1'b0;
      else if (p1_req_ready) last_p1 <= 1'b1;
   end

   assign win0 = elig0 & (~elig1 | last_p1);
`else
   assign win0 = elig0;
`endif
   assign win1 = elig1 & ~win0;

   // Slots are empty during reset, so gate the grant explicitly to keep it low.
   assign p0_req_ready = reset_n & win0;
   assign p1_req_ready = reset_n & win1;

   // ---- shared ALU on the granted port's operands ----
   always_comb begin
      sel_a     = p0_A;
      sel_b     = p0_B;
      sel_op    = p0_ALUOp;
      sel_shamt = p0_shamt;
      if (p1_req_ready) begin
         sel_a     = p1_A;
         sel_b     = p1_B;
         sel_op    = p1_ALUOp;
         sel_shamt = p1_shamt;
      end
   end

   assign alu_c        = alu_eval($signed(sel_a), $signed(sel_b), sel_op);
   assign unused_shamt = ^sel_shamt;

   // ---- response slots ----
   // A grant takes precedence over a drain in the same cycle, so the slot
   // stays full with the fresh result.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         full0 <= 1'b0;
         full1 <= 1'b0;
         p0_C  <= '0;
         p1_C  <= '0;
      end else begin
         if (p0_req_ready) begin
            full0 <= 1'b1;
            p0_C  <= alu_c;
         end else if (p0_resp_ready) begin
            full0 <= 1'b0;
         end
         if (p1_req_ready) begin
            full1 <= 1'b1;
            p1_C  <= alu_c;
         end else if (p1_resp_ready) begin
            full1 <= 1'b0;
         end
      end
   end

   assign p0_resp_valid = full0;
   assign p1_resp_valid = full1;

endmodule
